// File: rtl/rggen_bit_field_access_arbiter_if.sv
// Host/bit-field bundle for rggen_bit_field_access_arbiter.
// Host-side request lines come in, the shared bit field access port goes out.
// The "slave" modport is the arbiter's view.
// The "master" modport is the hosts'/field's view.
interface rggen_bit_field_access_arbiter_if #(
    parameter int REQUESTERS = 2,
    parameter int WIDTH      = 1
);
    logic [REQUESTERS-1:0]       i_request;
    logic [REQUESTERS-1:0]       i_write;
    logic [REQUESTERS*WIDTH-1:0] i_write_data;
    logic [REQUESTERS*WIDTH-1:0] i_write_mask;
    logic [REQUESTERS-1:0]       o_ack;
    logic [WIDTH-1:0]            o_read_data;
    logic                        o_busy;
    logic                        o_bf_valid;
    logic [WIDTH-1:0]            o_bf_read_mask;
    logic [WIDTH-1:0]            o_bf_write_mask;
    logic [WIDTH-1:0]            o_bf_write_data;
    logic [WIDTH-1:0]            i_bf_read_data;

    modport slave (
        input  i_request,
        input  i_write,
        input  i_write_data,
        input  i_write_mask,
        output o_ack,
        output o_read_data,
        output o_busy,
        output o_bf_valid,
        output o_bf_read_mask,
        output o_bf_write_mask,
        output o_bf_write_data,
        input  i_bf_read_data
    );

    modport master (
        output i_request,
        output i_write,
        output i_write_data,
        output i_write_mask,
        input  o_ack,
        input  o_read_data,
        input  o_busy,
        input  o_bf_valid,
        input  o_bf_read_mask,
        input  o_bf_write_mask,
        input  o_bf_write_data,
        output i_bf_read_data
    );
endinterface

// File: rtl/rggen_bit_field_access_arbiter.sv
// Round-robin arbiter that shares one bit field access port between several
// hosts. It performs exactly one access per grant, in three phases:
// - IDLE:     arbitrate and register the winning request.
// - ACCESS:   one-cycle strobe to the field; the pre-update read value is captured.
// - RESPONSE: one-cycle ack to the granted host.
// Reads can have side effects (rc / w01src fields), so each grant must map to
// exactly one strobe, and an aborted access must never be acknowledged.
module rggen_bit_field_access_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int WIDTH      = 1
)(
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    rggen_bit_field_access_arbiter_if.slave        bus_if
);

    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_RESPONSE = 2'd2
    } state_t;

    // One-hot decode of a grant index into the ack vector.
    function automatic logic [REQUESTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [REQUESTERS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    state_t                  state_q;
    logic [IDX_W-1:0]        grant_q;
    logic [IDX_W-1:0]        last_grant_q;
    logic [REQUESTERS-1:0]   ack_q;
    logic [WIDTH-1:0]        read_data_q;
    logic                    busy_q;
    logic                    bf_valid_q;
    logic [WIDTH-1:0]        bf_read_mask_q;
    logic [WIDTH-1:0]        bf_write_mask_q;
    logic [WIDTH-1:0]        bf_write_data_q;

    logic [WIDTH-1:0]        host_wdata_s [REQUESTERS];
    logic [WIDTH-1:0]        host_wmask_s [REQUESTERS];
    logic [IDX_W:0]          cand_s;
    logic                    grant_valid_d;
    logic [IDX_W-1:0]        grant_d;
    logic                    sel_write_d;
    logic [WIDTH-1:0]        sel_wdata_d;
    logic [WIDTH-1:0]        sel_wmask_d;

    // Split the flat per-host data/mask buses into per-host slices.
    always_comb begin
        for (int h = 0; h < REQUESTERS; h++) begin
            host_wdata_s[h] = bus_if.i_write_data[h*WIDTH +: WIDTH];
            host_wmask_s[h] = bus_if.i_write_mask[h*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: the first requester at or above last_grant+1, wrapping to 0.
    always_comb begin
        grant_valid_d = 1'b0;
        grant_d       = '0;
        sel_write_d   = 1'b0;
        sel_wdata_d   = '0;
        sel_wmask_d   = '0;
        cand_s        = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            // last_grant+1+k never exceeds 2*REQUESTERS-1, so a single
            // conditional subtract is enough for the modulo.
            cand_s = {1'b0, last_grant_q} + (IDX_W+1)'(1) + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(REQUESTERS)) begin
                cand_s = cand_s - (IDX_W+1)'(REQUESTERS);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_valid_d && bus_if.i_request[cand_s[IDX_W-1:0]]) begin
                grant_valid_d = 1'b1;
                grant_d       = cand_s[IDX_W-1:0];
                sel_write_d   = bus_if.i_write[cand_s[IDX_W-1:0]];
                sel_wdata_d   = host_wdata_s[cand_s[IDX_W-1:0]];
                sel_wmask_d   = host_wmask_s[cand_s[IDX_W-1:0]];
            end else begin
                grant_valid_d = grant_valid_d;
            end
        end
    end

    // Access sequencer: the state machine together with every registered output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            last_grant_q    <= IDX_W'(REQUESTERS - 1);
            ack_q           <= '0;
            read_data_q     <= '0;
            busy_q          <= 1'b0;
            bf_valid_q      <= 1'b0;
            bf_read_mask_q  <= '0;
            bf_write_mask_q <= '0;
            bf_write_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= '0;
                    if (grant_valid_d) begin
                        state_q      <= ST_ACCESS;
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        busy_q       <= 1'b1;
                        bf_valid_q   <= 1'b1;
                        // A write with an all-zero mask is still a write:
                        // the read mask stays clear.
                        if (sel_write_d) begin
                            bf_read_mask_q  <= '0;
                            bf_write_mask_q <= sel_wmask_d;
                            bf_write_data_q <= sel_wdata_d;
                        end else begin
                            bf_read_mask_q  <= '1;
                            bf_write_mask_q <= '0;
                            bf_write_data_q <= '0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Capture the field value seen during the strobe,
                    // i.e. before any read/write side effect lands.
                    state_q         <= ST_RESPONSE;
                    read_data_q     <= bus_if.i_bf_read_data;
                    ack_q           <= idx_to_onehot(grant_q);
                    bf_valid_q      <= 1'b0;
                    bf_read_mask_q  <= '0;
                    bf_write_mask_q <= '0;
                    bf_write_data_q <= '0;
                end
                ST_RESPONSE: begin
                    // The following IDLE cycle gives the host time to
                    // drop its request before re-arbitration.
                    state_q <= ST_IDLE;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q         <= ST_IDLE;
                    ack_q           <= '0;
                    busy_q          <= 1'b0;
                    bf_valid_q      <= 1'b0;
                    bf_read_mask_q  <= '0;
                    bf_write_mask_q <= '0;
                    bf_write_data_q <= '0;
                end
            endcase
        end
    end

    assign bus_if.o_ack           = ack_q;
    assign bus_if.o_read_data     = read_data_q;
    assign bus_if.o_busy          = busy_q;
    assign bus_if.o_bf_valid      = bf_valid_q;
    assign bus_if.o_bf_read_mask  = bf_read_mask_q;
    assign bus_if.o_bf_write_mask = bf_write_mask_q;
    assign bus_if.o_bf_write_data = bf_write_data_q;

endmodule
